// File: rtl/alu_issue_if.sv
// Instruction issue handshake between the fetch/dispatch side and alu_issue.
// Carries one RV32I instruction and its PC per valid/ready transfer.
interface alu_issue_if;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] pc;

    modport master (
        output instrValid,
        output instr,
        output pc,
        input  instrReady
    );

    modport slave (
        input  instrValid,
        input  instr,
        input  pc,
        output instrReady
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback controller in front of the multi-cycle alu.
// Decodes one instruction, drives operands, waits for done, writes back.
module alu_issue #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    alu_issue_if.slave  fetch,
    output logic [4:0]  rs1Addr_o,
    output logic [4:0]  rs2Addr_o,
    input  logic [31:0] rs1Data_i,
    input  logic [31:0] rs2Data_i,
    output logic        aluRst_o,
    output logic [31:0] aluArg1_o,
    output logic [31:0] aluArg2_o,
    output logic [2:0]  aluFunct3_o,
    output logic        aluSubSr_o,
    input  logic [31:0] aluRes_i,
    input  logic        aluDone_i,
    output logic [4:0]  rdAddr_o,
    output logic [31:0] rdData_o,
    output logic        rdWe_o,
    output logic        illegal_o,
    output logic        timeout_o
);
    localparam logic [6:0]  OP_REG   = 7'b0110011;
    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC = 7'b0010111;
    localparam logic [15:0] LAST     = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        WB
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [15:0] cnt_q;
    logic        accept;
    logic        legal;
    logic        done_hit;
    logic        time_up;
    logic [6:0]  in_op;
    logic [2:0]  f3;
    logic [31:0] arg1_d;
    logic [31:0] arg2_d;
    logic [2:0]  f3_d;
    logic        sub_d;

    assign fetch.instrReady = (state_q == IDLE);
    assign accept           = fetch.instrValid && fetch.instrReady;
    assign in_op            = fetch.instr[6:0];
    assign legal            = (in_op == OP_REG) || (in_op == OP_IMM)
                           || (in_op == OP_LUI) || (in_op == OP_AUIPC);

    assign rs1Addr_o = instr_q[19:15];
    assign rs2Addr_o = instr_q[24:20];
    assign rdAddr_o  = instr_q[11:7];
    assign f3        = instr_q[14:12];

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        done_hit = 1'b0;
        time_up  = 1'b0;
        aluRst_o = rst_i;
        rdWe_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && legal) state_d = LOAD;
            end
            LOAD: begin
                aluRst_o = 1'b1;
                state_d  = EXEC;
            end
            EXEC: begin
                // A done on the last allowed cycle still wins over the timeout.
                if (aluDone_i) begin
                    done_hit = 1'b1;
                    state_d  = WB;
                end else if (cnt_q == LAST) begin
                    time_up = 1'b1;
                    state_d = IDLE;
                end
            end
            WB: begin
                rdWe_o  = (instr_q[11:7] != 5'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand build from the latched instruction and live regfile data.
    always_comb begin
        arg1_d = rs1Data_i;
        arg2_d = rs2Data_i;
        f3_d   = f3;
        sub_d  = 1'b0;
        unique case (instr_q[6:0])
            OP_REG: sub_d = instr_q[30];
            OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101)
                    arg2_d = {27'd0, instr_q[24:20]};
                else
                    arg2_d = {{20{instr_q[31]}}, instr_q[31:20]};
                sub_d = (f3 == 3'b101) && instr_q[30];
            end
            OP_LUI: begin
                arg1_d = 32'd0;
                arg2_d = {instr_q[31:12], 12'd0};
                f3_d   = 3'b000;
            end
            OP_AUIPC: begin
                arg1_d = pc_q;
                arg2_d = {instr_q[31:12], 12'd0};
                f3_d   = 3'b000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q     <= '0;
            pc_q        <= '0;
            cnt_q       <= '0;
            aluArg1_o   <= '0;
            aluArg2_o   <= '0;
            aluFunct3_o <= '0;
            aluSubSr_o  <= 1'b0;
            rdData_o    <= '0;
            illegal_o   <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            illegal_o <= accept && !legal;
            timeout_o <= time_up;
            if (accept && legal) begin
                instr_q <= fetch.instr;
                pc_q    <= fetch.pc;
            end
            if (state_q == EXEC) cnt_q <= cnt_q + 16'd1;
            else                 cnt_q <= '0;
            if (state_q == LOAD) begin
                aluArg1_o   <= arg1_d;
                aluArg2_o   <= arg2_d;
                aluFunct3_o <= f3_d;
                aluSubSr_o  <= sub_d;
            end
            if (done_hit) rdData_o <= aluRes_i;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue; the bench plays regfile and alu.
// Expected writebacks are queued at issue and popped on rdWe_o.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] regs [32];
    logic [4:0]  rs1Addr, rs2Addr, rdAddr;
    logic [31:0] rs1Data, rs2Data;
    logic        aluRst, aluSubSr, aluDone, rdWe, illegal, timeout;
    logic [31:0] aluArg1, aluArg2, aluRes, rdData;
    logic [2:0]  aluFunct3;
    int          nvec = 0;
    int          nerr = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    wb_t sb[$];

    alu_issue_if fif ();

    alu_issue #(.TIMEOUT(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .fetch       (fif.slave),
        .rs1Addr_o   (rs1Addr),
        .rs2Addr_o   (rs2Addr),
        .rs1Data_i   (rs1Data),
        .rs2Data_i   (rs2Data),
        .aluRst_o    (aluRst),
        .aluArg1_o   (aluArg1),
        .aluArg2_o   (aluArg2),
        .aluFunct3_o (aluFunct3),
        .aluSubSr_o  (aluSubSr),
        .aluRes_i    (aluRes),
        .aluDone_i   (aluDone),
        .rdAddr_o    (rdAddr),
        .rdData_o    (rdData),
        .rdWe_o      (rdWe),
        .illegal_o   (illegal),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    assign rs1Data = regs[rs1Addr];
    assign rs2Data = regs[rs2Addr];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0] f,
                                              input logic s);
        unique case (f)
            3'b000: alu_model = s ? a - b : a + b;
            3'b001: alu_model = a << b[4:0];
            3'b010: alu_model = {31'd0, $signed(a) < $signed(b)};
            3'b011: alu_model = {31'd0, a < b};
            3'b100: alu_model = a ^ b;
            3'b101: alu_model = s ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110: alu_model = a | b;
            default: alu_model = a & b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && rdWe) begin
            if (sb.size() == 0) begin
                check("wb_spurious", 32'(rdWe), 32'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_rd", 32'(rdAddr), 32'(e.rd));
                check("wb_data", rdData, e.data);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!fif.instrReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(fif.instrReady), 32'd1);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        wait_ready();
        fif.instrValid = 1'b1;
        fif.instr      = ins;
        fif.pc         = pc;
        @(negedge clk);
        fif.instrValid = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] ins, input logic [31:0] pc,
                          input int dly, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [2:0] f3,
                          input logic sub, input logic [31:0] res);
        logic [4:0] rd;
        rd = ins[11:7];
        if (rd != 5'd0) sb.push_back('{rd: rd, data: res});
        issue(ins, pc);
        check("load_alurst", 32'(aluRst), 32'd1);
        check("load_ready", 32'(fif.instrReady), 32'd0);
        @(negedge clk);
        check("exec_alurst", 32'(aluRst), 32'd0);
        check("arg1", aluArg1, a1);
        check("arg2", aluArg2, a2);
        check("funct3", 32'(aluFunct3), 32'(f3));
        check("subsr", 32'(aluSubSr), 32'(sub));
        for (int k = 1; k <= dly; k++) begin
            if (k > 1) @(negedge clk);
            if (k == dly) begin
                aluDone = 1'b1;
                aluRes  = alu_model(aluArg1, aluArg2, aluFunct3, aluSubSr);
            end
        end
        @(negedge clk);
        aluDone = 1'b0;
        check("wb_we", 32'(rdWe), 32'(rd != 5'd0));
        check("wb_rdaddr", 32'(rdAddr), 32'(rd));
        @(negedge clk);
        check("post_ready", 32'(fif.instrReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1]        = 32'd5;
        regs[2]        = 32'd7;
        fif.instrValid = 1'b0;
        fif.instr      = 32'd0;
        fif.pc         = 32'd0;
        aluDone        = 1'b0;
        aluRes         = 32'd0;

        @(negedge clk);
        check("rst_alurst", 32'(aluRst), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(fif.instrReady), 32'd1);
        check("rst_we", 32'(rdWe), 32'd0);
        check("rst_arg1", aluArg1, 32'd0);
        check("rst_rddata", rdData, 32'd0);
        check("rst_alurst_off", 32'(aluRst), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        run_op(32'h002081B3, 32'h0, 3, 32'd5, 32'd7, 3'b000, 1'b0, 32'd12);
        run_op(32'h402081B3, 32'h0, 2, 32'd5, 32'd7, 3'b000, 1'b1,
               32'hFFFFFFFE);
        run_op(32'hFFF00293, 32'h0, 1, 32'd0, 32'hFFFFFFFF, 3'b000, 1'b0,
               32'hFFFFFFFF);
        regs[1] = 32'hF0000000;
        run_op(32'h4040D313, 32'h0, 4, 32'hF0000000, 32'd4, 3'b101, 1'b1,
               32'hFF000000);
        regs[1] = 32'd5;
        run_op(32'h123453B7, 32'h0, 2, 32'd0, 32'h12345000, 3'b000, 1'b0,
               32'h12345000);
        run_op(32'h12345037, 32'h0, 1, 32'd0, 32'h12345000, 3'b000, 1'b0,
               32'h12345000);
        run_op(32'h00001097, 32'h100, 2, 32'h100, 32'h1000, 3'b000, 1'b0,
               32'h1100);

        issue(32'h0000007F, 32'h0);
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_ready", 32'(fif.instrReady), 32'd1);
        check("ill_alurst", 32'(aluRst), 32'd0);
        @(negedge clk);
        check("ill_clear", 32'(illegal), 32'd0);
        check("ill_alurst2", 32'(aluRst), 32'd0);

        issue(32'h002081B3, 32'h0);
        for (int k = 0; k < 8; k++) @(negedge clk);
        check("to_not_yet", 32'(timeout), 32'd0);
        check("to_busy", 32'(fif.instrReady), 32'd0);
        @(negedge clk);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_ready", 32'(fif.instrReady), 32'd1);
        check("to_no_we", 32'(rdWe), 32'd0);
        @(negedge clk);
        check("to_clear", 32'(timeout), 32'd0);

        issue(32'h002081B3, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_alurst", 32'(aluRst), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check("mid_ready", 32'(fif.instrReady), 32'd1);
        check("mid_arg1", aluArg1, 32'd0);
        check("mid_arg2", aluArg2, 32'd0);
        check("mid_rdaddr", 32'(rdAddr), 32'd0);
        check("mid_we", 32'(rdWe), 32'd0);
        check("mid_to", 32'(timeout), 32'd0);

        run_op(32'h002081B3, 32'h0, 1, 32'd5, 32'd7, 3'b000, 1'b0, 32'd12);
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
